fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
- Parametrised successor to the two-source EX-stage forwarding unit.
- Generalised to NUM_SRC operands and REG_AW-bit register addresses.
- Fixes MEM/WB forwarding priority: MEM/WB is no longer suppressed by any EX/MEM write, only by a matching one.
- Adds load-use stall detection and a scoreboard for a fixed-latency multi-cycle unit (mul/div).
- Sits beside the ID/EX pipeline registers; drives ALU operand muxes, PC/IF-ID hold and ID/EX bubble insertion.

Parameters:
- REG_AW, 5, register address width.
- NUM_SRC, 2, source operands per instruction (1..4).
- MC_LAT, 4, multi-cycle unit latency in cycles from issue to result (2..15).
- MC_DEPTH, 2, max in-flight multi-cycle ops, i.e. scoreboard entries (1..8).

Ports:
- clk  in  1  clock.
- arst_n  in  1  asynchronous active-low reset.
- rs_id  in  NUM_SRC*REG_AW  source addresses of the instruction in ID; slot k = bits [k*REG_AW +: REG_AW].
- rs_used_id  in  NUM_SRC  per-source valid mask for ID.
- rd_id  in  REG_AW  destination of the ID instruction.
- reg_write_id  in  1  ID instruction writes rd_id.
- mc_op_id  in  1  ID instruction targets the multi-cycle unit.
- rs_ex  in  NUM_SRC*REG_AW  source addresses held in ID/EX.
- rd_ex  in  REG_AW  destination held in ID/EX.
- reg_write_ex  in  1  write enable held in ID/EX.
- mem_read_ex  in  1  ID/EX instruction is a load.
- rd_mem  in  REG_AW  destination held in EX/MEM.
- reg_write_mem  in  1  write enable held in EX/MEM.
- rd_wb  in  REG_AW  destination held in MEM/WB.
- reg_write_wb  in  1  write enable held in MEM/WB.
- fwd_sel  out  NUM_SRC*2  per-source mux select: 00 regfile, 10 EX/MEM, 01 MEM/WB.
- stall_id  out  1  hold PC and IF/ID.
- flush_ex  out  1  load a bubble into ID/EX.
- mc_done  out  1  multi-cycle result valid this cycle.
- mc_done_rd  out  REG_AW  destination of the completing multi-cycle op.

Behaviour:
- Clock is clk; reset is asynchronous and active-low on arst_n. These are fixed.
- Reset: all scoreboard entries invalid, counters 0. Outputs: mc_done=0, mc_done_rd=0, stall_id=0, flush_ex=0, fwd_sel=0.
- Address 0 never matches anything: it is never forwarded, never stalls and is never entered in the scoreboard.
- Forwarding is combinational. Per source k:
  - 10 if reg_write_mem and rd_mem!=0 and rd_mem==rs_ex[k].
  - else 01 if reg_write_wb and rd_wb!=0 and rd_wb==rs_ex[k].
  - else 00.
- Load-use hazard (lu_haz): mem_read_ex and reg_write_ex and rd_ex!=0 and, for some k with rs_used_id[k]=1, rd_ex==rs_id[k].
- Scoreboard entry: valid bit, rd (REG_AW), down-counter (4 bits).
- sb_haz: some valid entry's rd equals rs_id[k] for a used k (RAW), or equals rd_id while reg_write_id=1 (WAW).
- full_haz: mc_op_id=1 and all MC_DEPTH entries are valid. An entry completing this cycle still counts as occupied.
- stall_id = lu_haz | sb_haz | full_haz. flush_ex = stall_id.
- Issue: mc_op_id & reg_write_id & !stall_id & rd_id!=0 loads the lowest-index free entry with rd_id and counter MC_LAT-1 at the clock edge.
- Each cycle, every valid entry with counter>0 decrements.
- A valid entry with counter==0 drives mc_done=1 and mc_done_rd=entry rd, both registered outputs, and is invalidated at the end of that cycle.
  - Fixed latency with single issue guarantees at most one completion per cycle.
  - A RAW dependent in ID therefore stalls through the mc_done cycle and is released the next cycle, after the regfile write.
- Timing: issue at edge T gives mc_done high in cycle T+MC_LAT.
- Simultaneous issue and completion are allowed; the freed slot becomes reusable only in the following cycle.
- Reset mid-operation: all in-flight ops are discarded and mc_done drops immediately (asynchronous).

Optional Feature:
- Macro: FWD_STATS_EN.
- When defined, adds two output ports:
  - stall_cnt (32): counts cycles with stall_id=1.
  - fwd_cnt (32): counts cycles with any fwd_sel!=00.
  - Both saturate at all-ones and reset to 0.
- When undefined, these ports and counters are absent and the remaining behaviour is identical.

Decomposition:
- Package fwd_pkg holds:
  - Constants FWD_NONE=2'b00, FWD_MEM=2'b10, FWD_WB=2'b01.
  - Scoreboard entry struct typedef (valid, rd, cnt).
  - Counter width constant.
- Sub-module mc_scoreboard: entries, issue/decrement/retire, hazard match vector.
- Top level: forwarding compare, load-use detection, stall merge, stats.

Test Plan:
- ADD x5 in EX/MEM and ADD x5 in MEM/WB; ID/EX reads rs1=x5 -> fwd_sel[1:0]=10. Drop reg_write_mem -> 01.
- EX/MEM writes x7 and MEM/WB writes x6; ID/EX reads rs1=x6 -> 01. This case was suppressed by the old unit.
- LW x3 in ID/EX; ID reads rs2=x3 with rs_used_id=2'b10 -> stall_id=flush_ex=1 for exactly 1 cycle. Same case with rs_used_id=2'b01 -> no stall.
- MUL x9 issued at edge T with MC_LAT=4 -> mc_done=1, mc_done_rd=9 in cycle T+4. Dependent ADD reading x9 stalls for cycles T+1..T+4 and proceeds in T+5.
- With MC_DEPTH=2, issue three back-to-back multi-cycle ops -> third stalls until the cycle after the first mc_done. Any op with rd=x0 never occupies an entry.
- Assert arst_n low in cycle T+2 of a pending MUL -> mc_done stays 0 and stall_id clears. With FWD_STATS_EN, stall_cnt returns to 0.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared constants and scoreboard entry type for the EX-stage forwarding/hazard unit.
package fwd_pkg;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b10;
  localparam logic [1:0] FWD_WB   = 2'b01;

  localparam int unsigned SB_CNT_W = 4;
  // Entry rd storage is sized for the widest supported register address.
  localparam int unsigned SB_RD_W  = 8;
  localparam int unsigned STAT_W   = 32;

  typedef struct packed {
    logic                valid;
    logic [SB_RD_W-1:0]  rd;
    logic [SB_CNT_W-1:0] cnt;
  } sb_entry_t;

endpackage

// File: rtl/fwd_hazard_unit_mc_scoreboard.sv
// Tracks in-flight fixed-latency multi-cycle ops: issue, countdown, retire,
// and RAW/WAW/full hazard matches against the instruction in ID.
module mc_scoreboard
  import fwd_pkg::*;
#(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned NUM_SRC  = 2,
  parameter int unsigned MC_LAT   = 4,
  parameter int unsigned MC_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      arst_n,
  input  logic [NUM_SRC*REG_AW-1:0] rs_id,
  input  logic [NUM_SRC-1:0]        rs_used_id,
  input  logic [REG_AW-1:0]         rd_id,
  input  logic                      reg_write_id,
  input  logic                      issue,
  output logic [NUM_SRC-1:0]        raw_match_c,
  output logic                      waw_match_c,
  output logic                      full_c,
  output logic                      mc_done,
  output logic [REG_AW-1:0]         mc_done_rd
);

  sb_entry_t [MC_DEPTH-1:0] sb_q, sb_d;
  logic                     mc_done_q, mc_done_d;
  logic [REG_AW-1:0]        mc_done_rd_q, mc_done_rd_d;
  logic                     issued;
  logic [REG_AW-1:0]        rs_k;

  // Retire finished entries, count down the rest, fill the lowest free slot.
  always_comb begin
    sb_d   = sb_q;
    issued = 1'b0;
    for (int i = 0; i < int'(MC_DEPTH); i++) begin
      if (sb_q[i].valid) begin
        if (sb_q[i].cnt == '0) begin
          sb_d[i] = '0;
        end else begin
          sb_d[i].cnt = sb_q[i].cnt - SB_CNT_W'(1);
        end
      end else if (issue && !issued) begin
        sb_d[i].valid = 1'b1;
        sb_d[i].rd    = SB_RD_W'(rd_id);
        sb_d[i].cnt   = SB_CNT_W'(MC_LAT - 1);
        issued        = 1'b1;
      end
    end
  end

  // Completion is flagged in the cycle an entry sits at zero.
  always_comb begin
    mc_done_d    = 1'b0;
    mc_done_rd_d = '0;
    for (int i = 0; i < int'(MC_DEPTH); i++) begin
      if (sb_d[i].valid && (sb_d[i].cnt == '0)) begin
        mc_done_d    = 1'b1;
        mc_done_rd_d = REG_AW'(sb_d[i].rd);
      end
    end
  end

  always_comb begin
    raw_match_c = '0;
    waw_match_c = 1'b0;
    full_c      = 1'b1;
    rs_k        = '0;
    for (int i = 0; i < int'(MC_DEPTH); i++) begin
      if (!sb_q[i].valid) begin
        full_c = 1'b0;
      end
    end
    for (int k = 0; k < int'(NUM_SRC); k++) begin
      rs_k = rs_id[k*REG_AW +: REG_AW];
      for (int i = 0; i < int'(MC_DEPTH); i++) begin
        if (rs_used_id[k] && (rs_k != '0) && sb_q[i].valid &&
            (sb_q[i].rd == SB_RD_W'(rs_k))) begin
          raw_match_c[k] = 1'b1;
        end
      end
    end
    for (int i = 0; i < int'(MC_DEPTH); i++) begin
      if (reg_write_id && (rd_id != '0) && sb_q[i].valid &&
          (sb_q[i].rd == SB_RD_W'(rd_id))) begin
        waw_match_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sb_q         <= '0;
      mc_done_q    <= 1'b0;
      mc_done_rd_q <= '0;
    end else begin
      sb_q         <= sb_d;
      mc_done_q    <= mc_done_d;
      mc_done_rd_q <= mc_done_rd_d;
    end
  end

  assign mc_done    = mc_done_q;
  assign mc_done_rd = mc_done_rd_q;

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding, load-use and multi-cycle hazard detection.
// Optional FWD_STATS_EN adds saturating stall/forward cycle counters.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned NUM_SRC  = 2,
  parameter int unsigned MC_LAT   = 4,
  parameter int unsigned MC_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      arst_n,
  input  logic [NUM_SRC*REG_AW-1:0] rs_id,
  input  logic [NUM_SRC-1:0]        rs_used_id,
  input  logic [REG_AW-1:0]         rd_id,
  input  logic                      reg_write_id,
  input  logic                      mc_op_id,
  input  logic [NUM_SRC*REG_AW-1:0] rs_ex,
  input  logic [REG_AW-1:0]         rd_ex,
  input  logic                      reg_write_ex,
  input  logic                      mem_read_ex,
  input  logic [REG_AW-1:0]         rd_mem,
  input  logic                      reg_write_mem,
  input  logic [REG_AW-1:0]         rd_wb,
  input  logic                      reg_write_wb,
  output logic [NUM_SRC*2-1:0]      fwd_sel,
  output logic                      stall_id,
  output logic                      flush_ex,
  output logic                      mc_done,
  output logic [REG_AW-1:0]         mc_done_rd
`ifdef FWD_STATS_EN
  ,
  output logic [STAT_W-1:0]         stall_cnt,
  output logic [STAT_W-1:0]         fwd_cnt
`endif
);

  logic [NUM_SRC-1:0] raw_match_c;
  logic               waw_match_c;
  logic               full_c;
  logic               lu_haz_c;
  logic               issue_c;
  logic [REG_AW-1:0]  rs_ex_k;
  logic [REG_AW-1:0]  rs_id_k;

  // MEM/WB is only overridden by an EX/MEM write to the same register.
  always_comb begin
    fwd_sel = '0;
    rs_ex_k = '0;
    for (int k = 0; k < int'(NUM_SRC); k++) begin
      rs_ex_k = rs_ex[k*REG_AW +: REG_AW];
      if (reg_write_mem && (rd_mem != '0) && (rd_mem == rs_ex_k)) begin
        fwd_sel[k*2 +: 2] = FWD_MEM;
      end else if (reg_write_wb && (rd_wb != '0) && (rd_wb == rs_ex_k)) begin
        fwd_sel[k*2 +: 2] = FWD_WB;
      end else begin
        fwd_sel[k*2 +: 2] = FWD_NONE;
      end
    end
  end

  always_comb begin
    lu_haz_c = 1'b0;
    rs_id_k  = '0;
    for (int k = 0; k < int'(NUM_SRC); k++) begin
      rs_id_k = rs_id[k*REG_AW +: REG_AW];
      if (mem_read_ex && reg_write_ex && (rd_ex != '0) &&
          rs_used_id[k] && (rd_ex == rs_id_k)) begin
        lu_haz_c = 1'b1;
      end
    end
  end

  assign stall_id = lu_haz_c | (|raw_match_c) | waw_match_c | (mc_op_id & full_c);
  assign flush_ex = stall_id;
  assign issue_c  = mc_op_id & reg_write_id & ~stall_id & (rd_id != '0);

  mc_scoreboard #(
    .REG_AW  (REG_AW),
    .NUM_SRC (NUM_SRC),
    .MC_LAT  (MC_LAT),
    .MC_DEPTH(MC_DEPTH)
  ) u_sb (
    .clk         (clk),
    .arst_n      (arst_n),
    .rs_id       (rs_id),
    .rs_used_id  (rs_used_id),
    .rd_id       (rd_id),
    .reg_write_id(reg_write_id),
    .issue       (issue_c),
    .raw_match_c (raw_match_c),
    .waw_match_c (waw_match_c),
    .full_c      (full_c),
    .mc_done     (mc_done),
    .mc_done_rd  (mc_done_rd)
  );

`ifdef FWD_STATS_EN
  logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [STAT_W-1:0] fwd_cnt_q, fwd_cnt_d;

  // Saturating event counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (stall_id && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STAT_W'(1);
    end
    if ((|fwd_sel) && (fwd_cnt_q != '1)) begin
      fwd_cnt_d = fwd_cnt_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed self-checking bench for fwd_hazard_unit (default parameters).
module tb_fwd_hazard_unit;

  localparam int unsigned REG_AW   = 5;
  localparam int unsigned NUM_SRC  = 2;
  localparam int unsigned MC_LAT   = 4;
  localparam int unsigned MC_DEPTH = 2;

  logic                      clk = 1'b0;
  logic                      arst_n;
  logic [NUM_SRC*REG_AW-1:0] rs_id;
  logic [NUM_SRC-1:0]        rs_used_id;
  logic [REG_AW-1:0]         rd_id;
  logic                      reg_write_id;
  logic                      mc_op_id;
  logic [NUM_SRC*REG_AW-1:0] rs_ex;
  logic [REG_AW-1:0]         rd_ex;
  logic                      reg_write_ex;
  logic                      mem_read_ex;
  logic [REG_AW-1:0]         rd_mem;
  logic                      reg_write_mem;
  logic [REG_AW-1:0]         rd_wb;
  logic                      reg_write_wb;
  logic [NUM_SRC*2-1:0]      fwd_sel;
  logic                      stall_id;
  logic                      flush_ex;
  logic                      mc_done;
  logic [REG_AW-1:0]         mc_done_rd;
`ifdef FWD_STATS_EN
  logic [31:0]               stall_cnt;
  logic [31:0]               fwd_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  fwd_hazard_unit #(
    .REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .MC_LAT(MC_LAT), .MC_DEPTH(MC_DEPTH)
  ) dut (
    .clk(clk), .arst_n(arst_n),
    .rs_id(rs_id), .rs_used_id(rs_used_id), .rd_id(rd_id),
    .reg_write_id(reg_write_id), .mc_op_id(mc_op_id),
    .rs_ex(rs_ex), .rd_ex(rd_ex), .reg_write_ex(reg_write_ex),
    .mem_read_ex(mem_read_ex), .rd_mem(rd_mem), .reg_write_mem(reg_write_mem),
    .rd_wb(rd_wb), .reg_write_wb(reg_write_wb),
    .fwd_sel(fwd_sel), .stall_id(stall_id), .flush_ex(flush_ex),
    .mc_done(mc_done), .mc_done_rd(mc_done_rd)
`ifdef FWD_STATS_EN
    , .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic idle();
    rs_id = '0; rs_used_id = '0; rd_id = '0; reg_write_id = 1'b0; mc_op_id = 1'b0;
    rs_ex = '0; rd_ex = '0; reg_write_ex = 1'b0; mem_read_ex = 1'b0;
    rd_mem = '0; reg_write_mem = 1'b0; rd_wb = '0; reg_write_wb = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    arst_n = 1'b0;
    #2;
    n_chk++; if (mc_done !== 1'b0) begin $display("FAIL rst_mc_done: got %b exp 0", mc_done); n_fail++; end
    n_chk++; if (mc_done_rd !== 5'd0) begin $display("FAIL rst_mc_done_rd: got %0d exp 0", mc_done_rd); n_fail++; end
    n_chk++; if (stall_id !== 1'b0) begin $display("FAIL rst_stall: got %b exp 0", stall_id); n_fail++; end
    n_chk++; if (flush_ex !== 1'b0) begin $display("FAIL rst_flush: got %b exp 0", flush_ex); n_fail++; end
    n_chk++; if (fwd_sel !== 4'b0000) begin $display("FAIL rst_fwd_sel: got %b exp 0000", fwd_sel); n_fail++; end
`ifdef FWD_STATS_EN
    n_chk++; if (stall_cnt !== 32'd0) begin $display("FAIL rst_stall_cnt: got %0d exp 0", stall_cnt); n_fail++; end
    n_chk++; if (fwd_cnt !== 32'd0) begin $display("FAIL rst_fwd_cnt: got %0d exp 0", fwd_cnt); n_fail++; end
`endif
    tick();
    arst_n = 1'b1;
    tick();
  endtask

  task automatic test_forwarding();
    idle();
    rs_ex = {5'd0, 5'd5}; rd_mem = 5'd5; reg_write_mem = 1'b1; rd_wb = 5'd5; reg_write_wb = 1'b1;
    #1;
    n_chk++; if (fwd_sel !== 4'b0010) begin $display("FAIL fwd_mem_prio: got %b exp 0010", fwd_sel); n_fail++; end
    reg_write_mem = 1'b0;
    #1;
    n_chk++; if (fwd_sel !== 4'b0001) begin $display("FAIL fwd_wb_only: got %b exp 0001", fwd_sel); n_fail++; end
    rs_ex = {5'd7, 5'd6}; rd_mem = 5'd7; reg_write_mem = 1'b1; rd_wb = 5'd6; reg_write_wb = 1'b1;
    #1;
    n_chk++; if (fwd_sel !== 4'b1001) begin $display("FAIL fwd_wb_not_suppressed: got %b exp 1001", fwd_sel); n_fail++; end
    rs_ex = {5'd0, 5'd0}; rd_mem = 5'd0; rd_wb = 5'd0;
    #1;
    n_chk++; if (fwd_sel !== 4'b0000) begin $display("FAIL fwd_x0: got %b exp 0000", fwd_sel); n_fail++; end
    rs_ex = {5'd5, 5'd5}; rd_mem = 5'd5; reg_write_wb = 1'b0;
    #1;
    n_chk++; if (fwd_sel !== 4'b1010) begin $display("FAIL fwd_both_slots: got %b exp 1010", fwd_sel); n_fail++; end
    n_chk++; if (stall_id !== 1'b0) begin $display("FAIL fwd_no_stall: got %b exp 0", stall_id); n_fail++; end
    idle();
    tick();
  endtask

  task automatic test_load_use();
    idle();
    rd_ex = 5'd3; reg_write_ex = 1'b1; mem_read_ex = 1'b1;
    rs_id = {5'd3, 5'd1}; rs_used_id = 2'b10; rd_id = 5'd4; reg_write_id = 1'b1;
    #1;
    n_chk++; if (stall_id !== 1'b1) begin $display("FAIL lu_stall: got %b exp 1", stall_id); n_fail++; end
    n_chk++; if (flush_ex !== 1'b1) begin $display("FAIL lu_flush: got %b exp 1", flush_ex); n_fail++; end
    tick();
    // Load advances to MEM, dependent moves into ID/EX.
    rd_ex = 5'd0; reg_write_ex = 1'b0; mem_read_ex = 1'b0;
    rd_mem = 5'd3; reg_write_mem = 1'b1; rs_ex = {5'd3, 5'd1};
    rs_id = '0; rs_used_id = '0; rd_id = '0; reg_write_id = 1'b0;
    #1;
    n_chk++; if (stall_id !== 1'b0) begin $display("FAIL lu_release: got %b exp 0", stall_id); n_fail++; end
    n_chk++; if (fwd_sel !== 4'b1000) begin $display("FAIL lu_fwd_after: got %b exp 1000", fwd_sel); n_fail++; end
    tick();
    idle();
    rd_ex = 5'd3; reg_write_ex = 1'b1; mem_read_ex = 1'b1;
    rs_id = {5'd3, 5'd1}; rs_used_id = 2'b01;
    #1;
    n_chk++; if (stall_id !== 1'b0) begin $display("FAIL lu_unused_src: got %b exp 0", stall_id); n_fail++; end
    rd_ex = 5'd0; rs_id = {5'd0, 5'd0}; rs_used_id = 2'b11;
    #1;
    n_chk++; if (stall_id !== 1'b0) begin $display("FAIL lu_x0: got %b exp 0", stall_id); n_fail++; end
    idle();
    tick();
  endtask

  task automatic test_mc_latency();
    idle();
    rd_id = 5'd9; reg_write_id = 1'b1; mc_op_id = 1'b1;
    #1;
    n_chk++; if (stall_id !== 1'b0) begin $display("FAIL mc_issue_stall: got %b exp 0", stall_id); n_fail++; end
    tick();
    mc_op_id = 1'b0; rd_id = 5'd10; rs_id = {5'd0, 5'd9}; rs_used_id = 2'b01;
    for (int c = 1; c <= 5; c++) begin
      #1;
      n_chk++; if (stall_id !== (c <= 4)) begin $display("FAIL mc_raw_stall_c%0d: got %b exp %b", c, stall_id, (c <= 4)); n_fail++; end
      n_chk++; if (mc_done !== (c == 4)) begin $display("FAIL mc_done_c%0d: got %b exp %b", c, mc_done, (c == 4)); n_fail++; end
      if (c == 4) begin
        n_chk++; if (mc_done_rd !== 5'd9) begin $display("FAIL mc_done_rd: got %0d exp 9", mc_done_rd); n_fail++; end
      end
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_back_to_back();
    idle();
    rd_id = 5'd11; reg_write_id = 1'b1; mc_op_id = 1'b1;
    #1;
    n_chk++; if (stall_id !== 1'b0) begin $display("FAIL b2b_first: got %b exp 0", stall_id); n_fail++; end
    tick();
    rd_id = 5'd12;
    #1;
    n_chk++; if (stall_id !== 1'b0) begin $display("FAIL b2b_second: got %b exp 0", stall_id); n_fail++; end
    tick();
    rd_id = 5'd13;
    for (int c = 2; c <= 5; c++) begin
      #1;
      n_chk++; if (stall_id !== (c < 5)) begin $display("FAIL b2b_full_c%0d: got %b exp %b", c, stall_id, (c < 5)); n_fail++; end
      n_chk++; if (mc_done !== (c >= 4)) begin $display("FAIL b2b_done_c%0d: got %b exp %b", c, mc_done, (c >= 4)); n_fail++; end
      if (c == 4) begin
        n_chk++; if (mc_done_rd !== 5'd11) begin $display("FAIL b2b_rd_first: got %0d exp 11", mc_done_rd); n_fail++; end
      end
      if (c == 5) begin
        n_chk++; if (mc_done_rd !== 5'd12) begin $display("FAIL b2b_rd_second: got %0d exp 12", mc_done_rd); n_fail++; end
      end
      tick();
    end
    idle();
    for (int c = 6; c <= 10; c++) begin
      #1;
      n_chk++; if (mc_done !== (c == 9)) begin $display("FAIL b2b_third_done_c%0d: got %b exp %b", c, mc_done, (c == 9)); n_fail++; end
      if (c == 9) begin
        n_chk++; if (mc_done_rd !== 5'd13) begin $display("FAIL b2b_rd_third: got %0d exp 13", mc_done_rd); n_fail++; end
      end
      tick();
    end
  endtask

  task automatic test_x0_and_waw();
    idle();
    rd_id = 5'd0; reg_write_id = 1'b1; mc_op_id = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_chk++; if (stall_id !== 1'b0) begin $display("FAIL x0_issue_%0d: got %b exp 0", i, stall_id); n_fail++; end
      tick();
    end
    rd_id = 5'd14;
    #1;
    n_chk++; if (stall_id !== 1'b0) begin $display("FAIL x0_not_held_a: got %b exp 0", stall_id); n_fail++; end
    tick();
    rd_id = 5'd15;
    #1;
    n_chk++; if (stall_id !== 1'b0) begin $display("FAIL x0_not_held_b: got %b exp 0", stall_id); n_fail++; end
    tick();
    rd_id = 5'd16;
    #1;
    n_chk++; if (stall_id !== 1'b1) begin $display("FAIL full_stall: got %b exp 1", stall_id); n_fail++; end
    mc_op_id = 1'b0; rd_id = 5'd14;
    #1;
    n_chk++; if (stall_id !== 1'b1) begin $display("FAIL waw_stall: got %b exp 1", stall_id); n_fail++; end
    idle();
    for (int i = 0; i < 8; i++) tick();
    rd_id = 5'd14; reg_write_id = 1'b1;
    #1;
    n_chk++; if (stall_id !== 1'b0) begin $display("FAIL waw_cleared: got %b exp 0", stall_id); n_fail++; end
    idle();
    tick();
  endtask

  task automatic test_reset_mid_op();
    idle();
    rd_id = 5'd9; reg_write_id = 1'b1; mc_op_id = 1'b1;
    tick();
    mc_op_id = 1'b0; rd_id = 5'd10; rs_id = {5'd0, 5'd9}; rs_used_id = 2'b01;
    tick();
    #1;
    n_chk++; if (stall_id !== 1'b1) begin $display("FAIL rmid_pre_stall: got %b exp 1", stall_id); n_fail++; end
    arst_n = 1'b0;
    #1;
    n_chk++; if (stall_id !== 1'b0) begin $display("FAIL rmid_stall_clear: got %b exp 0", stall_id); n_fail++; end
    n_chk++; if (mc_done !== 1'b0) begin $display("FAIL rmid_done_low: got %b exp 0", mc_done); n_fail++; end
`ifdef FWD_STATS_EN
    n_chk++; if (stall_cnt !== 32'd0) begin $display("FAIL rmid_stall_cnt: got %0d exp 0", stall_cnt); n_fail++; end
`endif
    #1;
    arst_n = 1'b1;
    tick();
    for (int c = 0; c < 5; c++) begin
      n_chk++; if (mc_done !== 1'b0) begin $display("FAIL rmid_no_done_c%0d: got %b exp 0", c, mc_done); n_fail++; end
      n_chk++; if (stall_id !== 1'b0) begin $display("FAIL rmid_no_stall_c%0d: got %b exp 0", c, stall_id); n_fail++; end
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    arst_n = 1'b0;
    test_reset();
    test_forwarding();
    test_load_use();
    test_mc_latency();
    test_back_to_back();
    test_x0_and_waw();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
